// File: rtl/counter_pkg.sv
// counter_pkg: controller state encoding and default widths.
package counter_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  localparam int CNT_W_DEF = 8;
  localparam int PRESC_W_DEF = 8;
  localparam int WRAP_W_DEF = 8;
endpackage

// File: rtl/presc_tick.sv
// presc_tick: prescaler that ticks once per div+1 run cycles.
module presc_tick
  import counter_pkg::*;
#(
  parameter int W = PRESC_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         load,
  input  logic [W-1:0] div,
  output logic         tick
);
  logic [W-1:0] cnt;
  // compare against live div so a new divide value applies at the next compare
  assign tick = cnt == div;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: start/stop/clear FSM driving a downstream counter with prescaled
// increments, oneshot completion and a saturating wrap counter.
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               oneshot,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               overflow,
  output logic               count_en,
  output logic               count_clr,
  output logic               busy,
  output logic               done,
  output logic [WRAP_W-1:0]  wrap_cnt
);
  state_t state, nxt;
  logic tick, clr_q, run, fin;
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be positive");
  end
  assign run = state == RUN;
  assign fin = run && oneshot && overflow;
  assign busy = state == ARM || run;
  assign count_clr = clr_q || state == ARM;
  assign count_en = run && tick && !(oneshot && overflow) && !stop && !clear;
  presc_tick #(.W(PRESC_W)) u_presc (
    .clk (clk),
    .rst (rst),
    .run (run && !stop),
    .load(clear || state == ARM),
    .div (presc_div),
    .tick(tick)
  );
  // stop outranks start even in IDLE/DONE, where it otherwise does nothing
  always_comb begin
    nxt = state;
    if (clear || (stop && busy)) nxt = IDLE;
    else if (!stop && start && (state == IDLE || state == DONE)) nxt = ARM;
    else if (state == ARM) nxt = RUN;
    else if (fin) nxt = DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      clr_q <= 1'b0;
      done <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      state <= nxt;
      clr_q <= clear;
      done <= fin && !stop && !clear;
      if (clear || state == ARM) wrap_cnt <= '0;
      else if (count_en && overflow && !(&wrap_cnt)) wrap_cnt <= wrap_cnt + 1'b1;
    end
endmodule
